// File: rtl/mpadder_seq.sv
// mpadder_seq: control sequencer for the mpadder Montgomery datapath.
//
// Flow: IDLE -> LOOP (ITERS shift/add iterations) -> RESOLVE (one six-phase
// carry-propagate pass) -> SUB (six-phase subtract passes until the datapath
// reports completion on `carry`) -> DONE (one-cycle `done` pulse) -> IDLE.
//
// Every output comes straight from a flop. Each output flop is loaded from
// the next-state value, so the outputs always describe the state the
// sequencer is currently in.
//
// Optional feature macro: MPSEQ_TIMEOUT_EN
//   defined   : SUB gives up after MAX_PASSES passes without `carry`. The
//               block then enters DONE anyway and raises the sticky `timeout`
//               port, which stays set until the next accepted start or reset.
//   undefined : SUB repeats until `carry` is seen. The `timeout` port does
//               not exist.
module mpadder_seq #(
  parameter int ITERS      = 256,
  parameter int MAX_PASSES = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     carry,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(ITERS)-1:0] bit_idx,
  output logic                     c_doubleshift,
  output logic                     enableC,
  output logic                     subtract,
  output logic [3:0]               showFluffyPonies
`ifdef MPSEQ_TIMEOUT_EN
  ,
  output logic                     timeout
`endif
);

  localparam int IW = $clog2(ITERS);

  // State encoding (kept as plain constants for legacy tool flows)
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOOP    = 3'd1;
  localparam logic [2:0] S_RESOLVE = 3'd2;
  localparam logic [2:0] S_SUB     = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  localparam logic [IW-1:0] LAST_IDX   = IW'(ITERS - 1);
  localparam logic [2:0]    PHASE_LAST = 3'd5;
  localparam logic [2:0]    PASS_SAT   = 3'd7;
  // Pass-counter value held while the final allowed pass is running
  localparam logic [2:0]    PASS_LIMIT = 3'(MAX_PASSES - 1);
  // Phase select seen by the datapath while idle: bit 3 freezes the adder pipeline
  localparam logic [3:0]    PHASE_IDLE = 4'b1000;

  // Sequencer state
  logic [2:0]    state_q, state_d;
  logic [2:0]    phase_q, phase_d;
  logic [IW-1:0] bit_idx_q, bit_idx_d;
  logic [2:0]    pass_q, pass_d;
  logic          timeout_q, timeout_d;

  // Output flops and their next values
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          dshift_q, dshift_d;
  logic          sub_q, sub_d;
  logic [3:0]    sfp_q, sfp_d;

  // Next-state logic: advance the state, phase, iteration and pass counters
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    bit_idx_d = bit_idx_q;
    pass_d    = pass_q;
    timeout_d = timeout_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_LOOP;
          phase_d   = 3'd0;
          bit_idx_d = '0;
          pass_d    = 3'd0;
          timeout_d = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_LOOP: begin
        if (bit_idx_q == LAST_IDX) begin
          // Last iteration: wrap the index and start the carry-propagate pass
          state_d   = S_RESOLVE;
          phase_d   = 3'd0;
          bit_idx_d = '0;
        end else begin
          bit_idx_d = bit_idx_q + {{(IW-1){1'b0}}, 1'b1};
        end
      end

      S_RESOLVE: begin
        if (phase_q == PHASE_LAST) begin
          state_d = S_SUB;
          phase_d = 3'd0;
        end else begin
          phase_d = phase_q + 3'd1;
        end
      end

      S_SUB: begin
        if (phase_q == PHASE_LAST) begin
          phase_d = 3'd0;
          if (carry) begin
            state_d = S_DONE;
          end else begin
            // Another subtract pass is needed; the counter saturates
            pass_d = (pass_q == PASS_SAT) ? PASS_SAT : (pass_q + 3'd1);
`ifdef MPSEQ_TIMEOUT_EN
            if (pass_q == PASS_LIMIT) begin
              state_d   = S_DONE;
              timeout_d = 1'b1;
            end else begin
              state_d = S_SUB;
            end
`endif
          end
        end else begin
          phase_d = phase_q + 3'd1;
        end
      end

      S_DONE: begin
        // A start seen in this cycle is deliberately dropped
        state_d = S_IDLE;
        phase_d = 3'd0;
      end

      default: begin
        state_d = S_IDLE;
        phase_d = 3'd0;
      end
    endcase
  end

  // Output decode from the next state, so the output flops track the state flops
  always_comb begin
    busy_d   = (state_d != S_IDLE);
    done_d   = (state_d == S_DONE);
    dshift_d = (state_d == S_LOOP);
    sub_d    = (state_d == S_SUB);
    if ((state_d == S_RESOLVE) || (state_d == S_SUB)) begin
      sfp_d = {1'b0, phase_d};
    end else begin
      sfp_d = PHASE_IDLE;
    end
  end

  // State, counter and output registers with asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      phase_q   <= 3'd0;
      bit_idx_q <= '0;
      pass_q    <= 3'd0;
      timeout_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dshift_q  <= 1'b0;
      sub_q     <= 1'b0;
      sfp_q     <= PHASE_IDLE;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      bit_idx_q <= bit_idx_d;
      pass_q    <= pass_d;
      timeout_q <= timeout_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dshift_q  <= dshift_d;
      sub_q     <= sub_d;
      sfp_q     <= sfp_d;
    end
  end

  assign busy             = busy_q;
  assign done             = done_q;
  assign bit_idx          = bit_idx_q;
  assign c_doubleshift    = dshift_q;
  assign subtract         = sub_q;
  assign showFluffyPonies = sfp_q;
  // The C-register enable is not driven by this sequencer any more
  assign enableC          = 1'b0;

`ifdef MPSEQ_TIMEOUT_EN
  assign timeout = timeout_q;
`else
  // Without the pass limit the pass counter and timeout flag have no consumer
  logic unused_pass_s;
  assign unused_pass_s = ^{pass_q, PASS_LIMIT, timeout_q};
`endif

endmodule

// File: tb/tb_mpadder_seq.sv
// Self-checking bench for mpadder_seq (ITERS=4, MAX_PASSES=2).
// The expected outputs for each cycle come from a timeline model: the
// number of cycles since start was accepted and the number of subtract
// passes fix the whole output trace.
module tb_mpadder_seq;

  localparam int ITERS = 4;
  localparam int MAXP  = 2;
  localparam int IW    = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          carry;
  logic          busy;
  logic          done;
  logic [IW-1:0] bit_idx;
  logic          c_doubleshift;
  logic          enableC;
  logic          subtract;
  logic [3:0]    showFluffyPonies;
`ifdef MPSEQ_TIMEOUT_EN
  logic          timeout;
`endif

  int total = 0;
  int bad   = 0;
  logic exp_tmo = 1'b0;

  typedef struct packed {
    logic          busy;
    logic          done;
    logic          cds;
    logic          sub;
    logic [IW-1:0] bi;
    logic [3:0]    sfp;
  } exp_t;

  mpadder_seq #(.ITERS(ITERS), .MAX_PASSES(MAXP)) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .carry            (carry),
    .busy             (busy),
    .done             (done),
    .bit_idx          (bit_idx),
    .c_doubleshift    (c_doubleshift),
    .enableC          (enableC),
    .subtract         (subtract),
    .showFluffyPonies (showFluffyPonies)
`ifdef MPSEQ_TIMEOUT_EN
    ,
    .timeout          (timeout)
`endif
  );

  always #5 clk = ~clk;

  // Expected outputs n cycles after start was sampled, with pe subtract passes
  function automatic exp_t model(input int n, input int pe);
    exp_t e;
    int d;
    d = ITERS + 6 + 6 * pe + 1;
    e = '0;
    e.sfp = 4'b1000;
    if (n >= 1 && n <= ITERS) begin
      e.busy = 1'b1;
      e.cds  = 1'b1;
      e.bi   = IW'(n - 1);
    end else if (n > ITERS && n <= ITERS + 6) begin
      e.busy = 1'b1;
      e.sfp  = 4'(n - ITERS - 1);
    end else if (n > ITERS + 6 && n < d) begin
      e.busy = 1'b1;
      e.sub  = 1'b1;
      e.sfp  = 4'((n - ITERS - 7) % 6);
    end else if (n == d) begin
      e.busy = 1'b1;
      e.done = 1'b1;
    end
    return e;
  endfunction

  // One complete operation with p subtract passes (p=0: carry never set).
  // Starts in an idle cycle, ends in the idle cycle after DONE.
  task automatic run_op(input int p, input bit hold, input string tag);
    int   pe;
    int   d;
    bit   tmo_hit;
    exp_t e;
    pe = p;
    tmo_hit = 1'b0;
`ifdef MPSEQ_TIMEOUT_EN
    if (p == 0 || p > MAXP) begin
      pe = MAXP;
      tmo_hit = 1'b1;
    end
`endif
    d = ITERS + 6 + 6 * pe + 1;
    for (int n = 0; n <= d + 1; n++) begin
      if (n > 0) begin
        @(posedge clk);
        #1;
      end
      e = model(n, pe);
      if (n == 1) exp_tmo = 1'b0;
      if (n == d) exp_tmo = tmo_hit;
      total++;
      if (busy !== e.busy) begin
        bad++;
        $display("FAIL %s busy n=%0d got %b want %b", tag, n, busy, e.busy);
      end
      total++;
      if (done !== e.done) begin
        bad++;
        $display("FAIL %s done n=%0d got %b want %b", tag, n, done, e.done);
      end
      total++;
      if (c_doubleshift !== e.cds) begin
        bad++;
        $display("FAIL %s c_doubleshift n=%0d got %b want %b", tag, n, c_doubleshift, e.cds);
      end
      total++;
      if (subtract !== e.sub) begin
        bad++;
        $display("FAIL %s subtract n=%0d got %b want %b", tag, n, subtract, e.sub);
      end
      total++;
      if (bit_idx !== e.bi) begin
        bad++;
        $display("FAIL %s bit_idx n=%0d got %0d want %0d", tag, n, bit_idx, e.bi);
      end
      total++;
      if (showFluffyPonies !== e.sfp) begin
        bad++;
        $display("FAIL %s phase n=%0d got %b want %b", tag, n, showFluffyPonies, e.sfp);
      end
      total++;
      if (enableC !== 1'b0) begin
        bad++;
        $display("FAIL %s enableC n=%0d got %b want 0", tag, n, enableC);
      end
`ifdef MPSEQ_TIMEOUT_EN
      total++;
      if (timeout !== exp_tmo) begin
        bad++;
        $display("FAIL %s timeout n=%0d got %b want %b", tag, n, timeout, exp_tmo);
      end
`endif
      // Drive inputs for this cycle
      if (n == 0) start = 1'b1;
      else if (n == d + 1) start = hold;
      else start = hold ? 1'b1 : 1'($urandom_range(0, 1));
      if (n > ITERS + 6 && ((n - ITERS - 6) % 6) == 0)
        carry = (p != 0) && (n == ITERS + 6 + 6 * p);
      else
        carry = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic check_reset_values(input string tag);
    total++;
    if ({busy, done, c_doubleshift, enableC, subtract} !== 5'b00000) begin
      bad++;
      $display("FAIL %s strobes got %b want 00000", tag,
               {busy, done, c_doubleshift, enableC, subtract});
    end
    total++;
    if (bit_idx !== 2'd0) begin
      bad++;
      $display("FAIL %s bit_idx got %0d want 0", tag, bit_idx);
    end
    total++;
    if (showFluffyPonies !== 4'b1000) begin
      bad++;
      $display("FAIL %s phase got %b want 1000", tag, showFluffyPonies);
    end
`ifdef MPSEQ_TIMEOUT_EN
    total++;
    if (timeout !== 1'b0) begin
      bad++;
      $display("FAIL %s timeout got %b want 0", tag, timeout);
    end
`endif
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b1;
    carry = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    start = 1'b0;
    carry = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    exp_tmo = 1'b0;
    @(posedge clk);
    #1;
    check_reset_values("reset_release");
  endtask

  task automatic test_single_pass();
    run_op(1, 1'b0, "single");
  endtask

  task automatic test_three_pass();
    run_op(3, 1'b0, "three_pass");
  endtask

  task automatic test_hold_start();
    run_op(2, 1'b1, "hold");
    run_op(1, 1'b0, "after_hold");
  endtask

  task automatic test_back_to_back();
    run_op(1, 1'b0, "b2b_a");
    run_op(2, 1'b0, "b2b_b");
  endtask

  task automatic test_reset_mid();
    start = 1'b1;
    for (int n = 1; n <= ITERS + 4; n++) begin
      @(posedge clk);
      #1;
      start = 1'($urandom_range(0, 1));
      carry = 1'($urandom_range(0, 1));
    end
    total++;
    if (showFluffyPonies !== 4'd3 || subtract !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid pre phase got %b/%b want 0011/0", showFluffyPonies, subtract);
    end
    #2;
    reset = 1'b1;
    #1;
    check_reset_values("reset_mid");
    #1;
    reset = 1'b0;
    start = 1'b0;
    exp_tmo = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      carry = 1'($urandom_range(0, 1));
      total++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL reset_mid idle k=%0d done/busy got %b%b want 00", k, done, busy);
      end
    end
    run_op(1, 1'b0, "after_reset_mid");
  endtask

  task automatic test_random();
    int p;
    int gap;
    for (int r = 0; r < 6; r++) begin
      p   = $urandom_range(1, 4);
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        @(posedge clk);
        #1;
        start = 1'b0;
        carry = 1'($urandom_range(0, 1));
        total++;
        if (busy !== 1'b0 || showFluffyPonies !== 4'b1000) begin
          bad++;
          $display("FAIL random_gap busy/phase got %b/%b want 0/1000", busy, showFluffyPonies);
        end
      end
      run_op(p, 1'b0, "random");
    end
  endtask

`ifdef MPSEQ_TIMEOUT_EN
  task automatic test_timeout();
    run_op(0, 1'b0, "timeout");
    run_op(1, 1'b0, "timeout_clear");
  endtask
`endif

  initial begin
    test_reset();
    test_single_pass();
    test_three_pass();
    test_hold_start();
    test_back_to_back();
    test_reset_mid();
    test_random();
`ifdef MPSEQ_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
